// File: rtl/stream_fifo.sv
// stream_fifo: valid/ready stream FIFO with a last-beat sideband, occupancy
// level, registered almost-full/almost-empty flags and a synchronous flush.
// Define STREAM_FIFO_PACKET_EN to build the store-and-forward packet mode;
// without it the FIFO is cut-through and m_last is plain sideband.
module stream_fifo #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int AFULL  = DEPTH - 4,
  parameter int AEMPTY = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WIDTH-1:0]       s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WIDTH-1:0]       m_data,
  output logic                   m_last,
  output logic [$clog2(DEPTH):0] level,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL   = LW'(AFULL);
  localparam logic [LW-1:0] AE_LVL   = LW'(AEMPTY);

  // Storage: {last, data} per entry; pointers carry one extra wrap bit.
  logic [WIDTH:0]  r_mem [DEPTH];
  logic [AW:0]     r_wptr;
  logic [AW:0]     r_rptr;

  // Stage p1: registered memory read. Stage p2: output register.
  logic [WIDTH:0]  r_beat_p1;
  logic            r_vld_p1;
  logic [WIDTH-1:0] r_data_p2;
  logic            r_last_p2;
  logic            r_vld_p2;

  // Occupancy (memory + both pipeline stages) and its flags.
  logic [LW-1:0]   r_level;
  logic            r_afull;
  logic            r_aempty;

  logic            w_push;
  logic            w_pop;
  logic            w_mem_nempty;
  logic            w_rd_gate;
  logic            w_rd_en;
  logic            w_load_p2;
  logic [LW-1:0]   w_level_nxt;

  assign s_ready      = (r_level != FULL_LVL) & ~flush;
  assign m_valid      = r_vld_p2;
  assign m_data       = r_data_p2;
  assign m_last       = r_last_p2;
  assign level        = r_level;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

  assign w_push       = s_valid & s_ready;
  assign w_pop        = r_vld_p2 & m_ready;
  assign w_mem_nempty = (r_wptr != r_rptr);
  // The output register takes a new beat when it is empty or being drained.
  assign w_load_p2    = r_vld_p1 & (~r_vld_p2 | m_ready);
  // Prefetch: read memory whenever stage p1 is free or moving on this cycle.
  assign w_rd_en      = w_mem_nempty & w_rd_gate & (~r_vld_p1 | w_load_p2);

`ifdef STREAM_FIFO_PACKET_EN
  // Gating is applied at the memory read so that once a beat leaves memory it
  // is never held back again: the first beat of a released packet reaches the
  // output two edges after its s_last is written, and the rest follows freely.
  // r_mem_pkts counts complete packets whose last beat is still in memory.
  logic [LW-1:0] r_mem_pkts;
  logic          r_rd_in_pkt;
  logic          w_rd_last;

  assign w_rd_last = r_mem[r_rptr[AW-1:0]][WIDTH];
  // A full FIFO forces cut-through so packets longer than DEPTH cannot stall.
  assign w_rd_gate = (r_mem_pkts != '0) | r_rd_in_pkt | (r_level == FULL_LVL);

  // Complete-packet count and mid-packet streaming flag on the read side.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_pkts  <= '0;
      r_rd_in_pkt <= 1'b0;
    end else if (flush) begin
      r_mem_pkts  <= '0;
      r_rd_in_pkt <= 1'b0;
    end else begin
      case ({w_push & s_last, w_rd_en & w_rd_last})
        2'b10:   r_mem_pkts <= r_mem_pkts + 1'b1;
        2'b01:   r_mem_pkts <= r_mem_pkts - 1'b1;
        default: r_mem_pkts <= r_mem_pkts;
      endcase
      if (w_rd_en) r_rd_in_pkt <= ~w_rd_last;
    end
  end
`else
  assign w_rd_gate = 1'b1;
`endif

  // Next occupancy: +1 on input handshake, -1 on output handshake.
  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  // Storage array write and registered read into stage p1 (no reset needed:
  // only entries between the pointers are ever consumed).
  always_ff @(posedge clk) begin
    if (w_push)  r_mem[r_wptr[AW-1:0]] <= {s_last, s_data};
    if (w_rd_en) r_beat_p1 <= r_mem[r_rptr[AW-1:0]];
  end

  // Pointers and pipeline valids; the output register holds while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_data_p2 <= '0;
      r_last_p2 <= 1'b0;
    end else if (flush) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
    end else begin
      if (w_push)  r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
      if (w_rd_en)        r_vld_p1 <= 1'b1;
      else if (w_load_p2) r_vld_p1 <= 1'b0;
      if (w_load_p2) begin
        r_vld_p2  <= 1'b1;
        r_data_p2 <= r_beat_p1[WIDTH-1:0];
        r_last_p2 <= r_beat_p1[WIDTH];
      end else if (w_pop) begin
        r_vld_p2  <= 1'b0;
      end
    end
  end

  // Occupancy and flags are registered together so they always agree.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_level  <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else if (flush) begin
      r_level  <= '0;
      r_afull  <= 1'b0;
      r_aempty <= 1'b1;
    end else begin
      r_level  <= w_level_nxt;
      r_afull  <= (w_level_nxt >= AF_LVL);
      r_aempty <= (w_level_nxt <= AE_LVL);
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: randomized and directed bench for stream_fifo (DEPTH=8).
// The reference is a plain queue of accepted beats; occupancy and flags are
// derived from its size. Packet-mode scenarios build with STREAM_FIFO_PACKET_EN.
module tb_stream_fifo;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int AFULL  = 6;
  localparam int AEMPTY = 2;

  typedef logic [WIDTH:0] beat_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [3:0]       level;
  logic             almost_full;
  logic             almost_empty;

  int    checks   = 0;
  int    failures = 0;
  beat_t mq[$];
  logic  hs_in, hs_out, stalled;
  beat_t got_beat, exp_beat;

  stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL(AFULL), .AEMPTY(AEMPTY)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock: sample handshakes mid-cycle, update the queue model at
  // the edge, return 1 time unit after the edge.
  task automatic tick();
    @(negedge clk);
    hs_in    = s_valid & s_ready & ~flush;
    hs_out   = m_valid & m_ready & ~flush;
    stalled  = m_valid & ~m_ready & ~flush & reset_n;
    got_beat = {m_last, m_data};
    @(posedge clk);
    exp_beat = 'x;
    if (!reset_n || flush) begin
      mq.delete();
    end else begin
      if (hs_out) begin
        if (mq.size() > 0) exp_beat = mq.pop_front();
        else               exp_beat = 'x;
      end
      if (hs_in) mq.push_back({s_last, s_data});
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({m_valid, m_last, m_data, level, almost_full, almost_empty} !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b l=%b d=%h lvl=%0d af=%b ae=%b, want 0 0 0000 0 0 1",
               m_valid, m_last, m_data, level, almost_full, almost_empty);
    end
    reset_n = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready: got %b want 1", s_ready); end
  endtask

  task automatic test_latency();
    s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b1; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    checks++;
    if (hs_in !== 1'b1) begin failures++; $display("FAIL lat_accept: got %b want 1", hs_in); end
    tick();
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL lat_n1_valid: got %b want 0", m_valid); end
    tick();
    checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b1, 16'h1234}) begin
      failures++; $display("FAIL lat_n2_out: got v=%b %b_%h want 1 1_1234", m_valid, m_last, m_data);
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (hs_out !== 1'b1 || got_beat !== exp_beat) begin
      failures++; $display("FAIL lat_pop: got hs=%b %h want 1 %h", hs_out, got_beat, exp_beat);
    end
    tick();
    checks++;
    if (m_valid !== 1'b0 || level !== 4'd0) begin
      failures++; $display("FAIL lat_empty: got v=%b lvl=%0d want 0 0", m_valid, level);
    end
  endtask

`ifndef STREAM_FIFO_PACKET_EN
  task automatic test_cut_through();
    s_valid = 1'b1; s_data = 16'h7E57; s_last = 1'b0; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 16'h7E57}) begin
      failures++; $display("FAIL ct_out: got v=%b %b_%h want 1 0_7e57", m_valid, m_last, m_data);
    end
    m_ready = 1'b1;
    tick();
    checks++;
    if (hs_out !== 1'b1 || got_beat !== exp_beat) begin
      failures++; $display("FAIL ct_pop: got hs=%b %h want 1 %h", hs_out, got_beat, exp_beat);
    end
  endtask
`endif

  task automatic test_fill_drain();
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = 16'(i); s_last = (i == DEPTH - 1);
      tick();
      checks++;
      if (hs_in !== 1'b1) begin failures++; $display("FAIL fill_accept[%0d]: got %b want 1", i, hs_in); end
      checks++;
      if (almost_full !== (i + 1 >= AFULL)) begin
        failures++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, (i + 1 >= AFULL));
      end
    end
    s_data = 16'h0099; s_last = 1'b0;
    checks++;
    if ({s_ready, level, almost_full, almost_empty} !== {1'b0, 4'd8, 1'b1, 1'b0}) begin
      failures++; $display("FAIL full_state: got rdy=%b lvl=%0d af=%b ae=%b want 0 8 1 0",
                           s_ready, level, almost_full, almost_empty);
    end
    tick();
    checks++;
    if (hs_in !== 1'b0) begin failures++; $display("FAIL full_reject: got %b want 0", hs_in); end
    s_valid = 1'b0; m_ready = 1'b1;
    tick();
    checks++;
    if (hs_out !== 1'b1 || got_beat[WIDTH-1:0] !== 16'h0000) begin
      failures++; $display("FAIL drain_first: got hs=%b d=%h want 1 0000", hs_out, got_beat[WIDTH-1:0]);
    end
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL drain_s_ready: got %b want 1", s_ready); end
    for (int k = 0; k < 40 && mq.size() > 0; k++) begin
      tick();
      if (hs_out) begin
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL drain_data: got %h want %h", got_beat, exp_beat); end
      end
      checks++;
      if (level !== 4'(mq.size())) begin failures++; $display("FAIL drain_level: got %0d want %0d", level, mq.size()); end
    end
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL drain_timeout: got %0d left want 0", mq.size()); end
  endtask

  task automatic test_random();
    int sent = 0;
    int cyc  = 0;
    while ((sent < 1000 || mq.size() > 0) && cyc < 8000) begin
      s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      s_data  = 16'($urandom);
      s_last  = (sent == 999) ? 1'b1 : ($urandom_range(0, 5) == 0);
      m_ready = (sent >= 1000) || ($urandom_range(0, 2) != 0);
      tick();
      cyc++;
      if (hs_in) sent++;
      if (hs_out) begin
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL rand_data: got %h want %h", got_beat, exp_beat); end
      end
      if (stalled) begin
        checks++;
        if ({m_valid, m_last, m_data} !== {1'b1, got_beat}) begin
          failures++; $display("FAIL rand_stall_hold: got v=%b %h want 1 %h", m_valid, {m_last, m_data}, got_beat);
        end
      end
      checks++;
      if ({level, s_ready, almost_full, almost_empty} !==
          {4'(mq.size()), mq.size() != DEPTH, mq.size() >= AFULL, mq.size() <= AEMPTY}) begin
        failures++; $display("FAIL rand_status: got lvl=%0d rdy=%b af=%b ae=%b want lvl=%0d",
                             level, s_ready, almost_full, almost_empty, mq.size());
      end
    end
    s_valid = 1'b0;
    checks++;
    if (sent != 1000 || mq.size() != 0) begin
      failures++; $display("FAIL rand_timeout: got sent=%0d left=%0d want 1000 0", sent, mq.size());
    end
  endtask

  task automatic test_back_to_back();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      s_data = 16'($urandom); s_last = 1'b1;
      tick();
      checks++;
      if (hs_in !== 1'b1) begin failures++; $display("FAIL b2b_in[%0d]: got %b want 1", k, hs_in); end
      checks++;
      if (hs_out !== (k >= 4)) begin failures++; $display("FAIL b2b_out[%0d]: got %b want %b", k, hs_out, (k >= 4)); end
      if (hs_out) begin
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL b2b_data: got %h want %h", got_beat, exp_beat); end
      end
    end
    s_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      tick();
      if (hs_out) begin
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL b2b_tail: got %h want %h", got_beat, exp_beat); end
      end
    end
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL b2b_timeout: got %0d left want 0", mq.size()); end
  endtask

  task automatic test_wrap();
    m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b1;
    for (int i = 0; i < DEPTH / 2; i++) begin s_data = 16'(16'h3000 + i); tick(); end
    m_ready = 1'b1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      s_data = 16'(16'h3100 + i);
      tick();
      checks++;
      if ({hs_in, hs_out, level} !== {1'b1, 1'b1, 4'd4}) begin
        failures++; $display("FAIL wrap_steady[%0d]: got in=%b out=%b lvl=%0d want 1 1 4", i, hs_in, hs_out, level);
      end
      checks++;
      if (got_beat !== exp_beat) begin failures++; $display("FAIL wrap_data: got %h want %h", got_beat, exp_beat); end
    end
    s_valid = 1'b0;
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      tick();
      if (hs_out) begin
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL wrap_tail: got %h want %h", got_beat, exp_beat); end
      end
    end
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL wrap_timeout: got %0d left want 0", mq.size()); end
  endtask

  task automatic test_flush();
    m_ready = 1'b0; s_valid = 1'b1; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin s_data = 16'(16'h0500 + i); tick(); end
    s_data = 16'h0BAD; flush = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL flush_s_ready: got %b want 0", s_ready); end
    tick();
    flush = 1'b0; s_valid = 1'b0;
    #1;
    checks++;
    if ({level, m_valid, almost_full, almost_empty, s_ready} !== {4'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL flush_state: got lvl=%0d v=%b af=%b ae=%b rdy=%b want 0 0 0 1 1",
                           level, m_valid, almost_full, almost_empty, s_ready);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL flush_stale: got %b want 0", m_valid); end
    end
    s_valid = 1'b1; s_data = 16'h0C0D; s_last = 1'b1;
    tick();
    s_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (hs_out) begin
        checks++;
        if (got_beat !== {1'b1, 16'h0C0D}) begin failures++; $display("FAIL flush_next: got %h want 10c0d", got_beat); end
      end
    end
    checks++;
    if (mq.size() != 0) begin failures++; $display("FAIL flush_timeout: got %0d left want 0", mq.size()); end
  endtask

  task automatic test_reset_midstream();
    int pops = 0;
    m_ready = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin s_data = 16'(16'h0100 + i); s_last = (i == 3); tick(); end
    s_valid = 1'b0;
    tick(); tick();
    checks++;
    if ({m_valid, level} !== {1'b1, 4'd8}) begin
      failures++; $display("FAIL rst_pre_stall: got v=%b lvl=%0d want 1 8", m_valid, level);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({m_valid, m_last, m_data, level, almost_full, almost_empty} !== {1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL rst_mid_outputs: got v=%b l=%b d=%h lvl=%0d af=%b ae=%b",
                           m_valid, m_last, m_data, level, almost_full, almost_empty);
    end
    tick();
    reset_n = 1'b1;
    #1;
    checks++;
    if ({s_ready, level} !== {1'b1, 4'd0}) begin
      failures++; $display("FAIL rst_release: got rdy=%b lvl=%0d want 1 0", s_ready, level);
    end
    s_valid = 1'b1; s_data = 16'hBEEF; s_last = 1'b1; m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (hs_in) s_valid = 1'b0;
      if (hs_out) begin
        pops++;
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL rst_new_beat: got %h want %h", got_beat, exp_beat); end
      end
    end
    checks++;
    if (pops != 1) begin failures++; $display("FAIL rst_pop_count: got %0d want 1", pops); end
  endtask

`ifdef STREAM_FIFO_PACKET_EN
  task automatic test_packet();
    int pops = 0;
    int sent = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 16'(16'hA0 + i); s_last = 1'b0;
      tick();
      s_valid = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL pkt_gate_beat[%0d]: got %b want 0", i, m_valid); end
      tick(); tick();
      checks++;
      if (m_valid !== 1'b0) begin failures++; $display("FAIL pkt_gate_gap[%0d]: got %b want 0", i, m_valid); end
    end
    s_valid = 1'b1; s_data = 16'hA3; s_last = 1'b1;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    tick();
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL pkt_n1_valid: got %b want 0", m_valid); end
    tick();
    checks++;
    if (m_valid !== 1'b1) begin failures++; $display("FAIL pkt_n2_valid: got %b want 1", m_valid); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if ({hs_out, got_beat} !== {1'b1, (k == 3), 16'(16'hA0 + k)}) begin
        failures++; $display("FAIL pkt_stream[%0d]: got hs=%b %h want 1 %h", k, hs_out, got_beat, {(k == 3), 16'(16'hA0 + k)});
      end
    end
    for (int k = 0; k < 80 && (sent < 12 || mq.size() > 0); k++) begin
      s_valid = (sent < 12); s_data = 16'(16'hC00 + sent); s_last = (sent == 11);
      tick();
      if (hs_in) sent++;
      if (hs_out) begin
        pops++;
        checks++;
        if (got_beat !== exp_beat) begin failures++; $display("FAIL pkt_long_data: got %h want %h", got_beat, exp_beat); end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (pops != 12) begin failures++; $display("FAIL pkt_long_deadlock: got %0d beats want 12", pops); end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
`ifndef STREAM_FIFO_PACKET_EN
    test_cut_through();
`endif
    test_fill_drain();
    test_back_to_back();
    test_wrap();
    test_random();
    test_flush();
    test_reset_midstream();
`ifdef STREAM_FIFO_PACKET_EN
    test_packet();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_fifo.md
# stream_fifo

Parametrised valid/ready stream FIFO: the successor to the single-width buffer. It adds a last-beat sideband, an occupancy level, programmable almost-full/almost-empty flags and a synchronous flush, plus an optional store-and-forward packet mode. It sits between PHY datapath stages (e.g. demodulator output to MAC framer) wherever rate decoupling or whole-packet buffering is needed.

## Interface
- `WIDTH`, 32, data bits per beat
- `DEPTH`, 1024, capacity in beats; power of two, ≥ 4
- `AFULL`, DEPTH-4, `almost_full` threshold (1..DEPTH)
- `AEMPTY`, 4, `almost_empty` threshold (0..DEPTH-1)
- `clk`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous clear; discards all stored beats
- `s_valid`  in  1  input beat valid
- `s_ready`  out  1  input beat accepted when `s_valid & s_ready`
- `s_data`  in  WIDTH  input data
- `s_last`  in  1  final beat of packet
- `m_valid`  out  1  output beat valid
- `m_ready`  in  1  downstream accepts
- `m_data`  out  WIDTH  output data
- `m_last`  out  1  final beat of packet
- `level`  out  $clog2(DEPTH)+1  beats held (memory + output pipeline)
- `almost_full`  out  1  `level >= AFULL`
- `almost_empty`  out  1  `level <= AEMPTY`

## Operation
- Storage: DEPTH×(WIDTH+1) array, data and last stored together; read/write pointers $clog2(DEPTH)+1 bits, MSB distinguishes full from empty on wrap.
- Write: on `s_valid & s_ready`, beat stored at write pointer, pointer increments modulo 2·DEPTH.
- `s_ready = (level != DEPTH) & ~flush`; derived from registered state only, never from `s_valid`/`m_ready`.
- Read pipeline: registered memory read feeding a registered output stage; prefetch keeps output stage full whenever data is available.
- `level`: +1 on input handshake, −1 on output handshake, unchanged when both in the same cycle. Never exceeds DEPTH, never underflows.
- Flags registered alongside `level` (same-cycle consistent with it).
- Output stall: while `m_valid & ~m_ready`, `m_data`/`m_last` hold stable; no beat lost or duplicated.
- Flush: cycle after `flush` high → pointers 0, `level` 0, `m_valid` 0, `almost_empty` 1, `almost_full` 0. Input handshake impossible during flush. Flush overrides simultaneous input/output.
- Reset (any time, including mid-packet or mid-stall): `s_ready` 1 once `reset_n` high, `m_valid` 0, `m_data` 0, `m_last` 0, `level` 0, `almost_full` 0, `almost_empty` 1; stored contents discarded.

## Timing
- Empty-FIFO latency: beat accepted at edge N appears with `m_valid` high after edge N+2.
- Throughput: one beat/cycle sustained in both directions with `m_ready` held high.
- Full: after DEPTH beats accepted with no output, `s_ready` low from the next cycle. It returns high the cycle after the first output handshake.
- Simultaneous write and read at `level == DEPTH`: not possible (`s_ready` low). At `level == 0` the write is accepted and the output follows the latency above.
- Flag update: one cycle after the handshake that crosses a threshold.

## Configuration
- `STREAM_FIFO_PACKET_EN` defined: store-and-forward. The registered count of complete packets (`s_last` beats written minus `m_last` beats read) gates the output. `m_valid` asserts only when count > 0 or the FIFO is full; the full case is a forced cut-through that prevents deadlock on packets larger than DEPTH. Once the first beat of a packet is presented, the rest of that packet streams without gating. Empty-FIFO latency is measured from the `s_last` handshake: N+2.
- Undefined: cut-through. `m_last` is carried as plain sideband and the packet counter is not built.

## Test plan
- Reset mid-stream: 10 beats in, `reset_n` low during a stall → all outputs at reset values, `level` 0; 1 new beat later → that beat out, nothing stale.
- Fill/drain DEPTH=8: 8 beats 0x0..0x7, `m_ready` low → `s_ready` low after beat 8, `level` 8, `almost_full` (AFULL=6) high. Drain → 0x0..0x7 in order, `s_ready` high the cycle after the first read.
- Throughput with random stalls: 1000 beats, random `m_ready`/`s_valid` → output equals input. `m_data` stable across every stall. With both always high, one beat/cycle after the 2-cycle latency.
- Wrap-around: 3×DEPTH beats at a steady half-full level → no corruption across pointer wrap, `level` constant.
- Flush: 5 beats stored, `flush` pulsed while `s_valid` high → `level` 0, `m_valid` 0 next cycle, flushed-cycle beat not stored.
- Packet mode (`STREAM_FIFO_PACKET_EN`): 4-beat packet with gaps → `m_valid` low until `s_last` accepted, then 4 consecutive beats with `m_last` on the 4th. A 12-beat packet into DEPTH=8 → forced cut-through, no deadlock.
